byte_word_packer: RTL and testbench

- Parametrised successor to the enabled 8-bit holding register: collects LANES narrow input beats into one wide output word.
- Lane 0 is least significant.
- Adds a valid/ready output handshake and a flush for partial words.
- Sits between a byte-serial source (UART/SPI front end) and a 32-bit word datapath.

---
 rtl/byte_word_packer_if.sv | 28 ++
 rtl/byte_word_packer.sv | 90 +++++++++
 tb/tb_byte_word_packer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/byte_word_packer_if.sv
// Beat-in / word-out handshake bundle for byte_word_packer.
// "slave" is the packer's view; "master" is the surrounding source/sink.
interface byte_word_packer_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LANES = 4
);
    localparam int unsigned OUT_W = IN_W * LANES;
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic             en;
    logic [IN_W-1:0]  in1;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] out1;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output en, in1, flush, out_ready,
        input  in_ready, out1, out_count, out_valid
    );

    modport slave (
        input  en, in1, flush, out_ready,
        output in_ready, out1, out_count, out_valid
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs LANES narrow beats (lane 0 least significant) into one wide word.
// The word is held under valid/ready, and a partial word can be flushed out.
module byte_word_packer #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LANES = 4
) (
    input logic clk,
    input logic rst,
    byte_word_packer_if.slave bus
);
    localparam int unsigned OUT_W = IN_W * LANES;
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    logic             slot_free;
    logic             last_lane;
    logic             in_ready;
    logic             accept;
    logic             load;
    logic [OUT_W-1:0] acc_ins;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        last_lane = (cnt_q == CNT_W'(LANES - 1));
        in_ready  = !last_lane || slot_free;
        accept    = bus.en && in_ready;
        cnt_inc   = cnt_q + CNT_W'(1);

        // Accumulator with the incoming beat merged into its lane; lanes above
        // cnt are always zero, so this is also the zero-padded flush word.
        acc_ins = acc_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (accept && (cnt_q == CNT_W'(i))) begin
                acc_ins[i*IN_W +: IN_W] = bus.in1;
            end
        end

        load = (accept && last_lane)
            || (bus.flush && slot_free && ((cnt_q != '0) || accept));

        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        count_d = count_q;
        valid_d = valid_q;

        if (load) begin
            out_d   = acc_ins;
            count_d = accept ? cnt_inc : cnt_q;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                acc_d = acc_ins;
                cnt_d = cnt_inc;
            end
            if (bus.out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out1      = out_q;
    assign bus.out_count = count_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// Randomised and directed bench for byte_word_packer against a queue-based model,
// plus a small IN_W=4, LANES=3 instance checked by hand.
module tb_byte_word_packer;
    localparam int LANES = 4;

    logic clk;
    logic rst;

    byte_word_packer_if #(.IN_W(8), .LANES(4)) bus ();
    byte_word_packer_if #(.IN_W(4), .LANES(3)) bus2 ();

    byte_word_packer #(.IN_W(8), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    byte_word_packer #(.IN_W(4), .LANES(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: beats collected so far, plus the word currently presented.
    logic [7:0]  pend[$];
    logic        m_hv;
    logic [31:0] m_word;
    int          m_cnt;
    logic        last_in_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pack_pending();
        logic [31:0] w = '0;
        foreach (pend[i]) w[i*8 +: 8] = pend[i];
        return w;
    endfunction

    task automatic model_clear();
        pend.delete();
        m_hv   = 1'b0;
        m_word = '0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive, compare mid-cycle, advance the model, cross the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] d,
                        input logic f, input logic o);
        logic sf, rdy;
        rst           = r;
        bus.en        = e;
        bus.in1       = d;
        bus.flush     = f;
        bus.out_ready = o;
        #4;
        sf  = !m_hv || o;
        rdy = (pend.size() != LANES - 1) || sf;
        last_in_ready = bus.in_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(m_hv));
        chk("out_count", 64'(bus.out_count), 64'(m_cnt));
        chk("out1", 64'(bus.out1), 64'(m_word));
        if (r) begin
            model_clear();
        end else begin
            if (e && rdy) pend.push_back(d);
            if ((pend.size() == LANES) || (f && sf && (pend.size() > 0))) begin
                m_word = pack_pending();
                m_cnt  = pend.size();
                m_hv   = 1'b1;
                pend.delete();
            end else if (m_hv && o) begin
                m_hv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic o);
        step(1'b0, 1'b1, d, 1'b0, o);
    endtask

    task automatic idle(input logic o);
        step(1'b0, 1'b0, 8'h00, 1'b0, o);
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.in1       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus2.en        = 1'b0;
        bus2.in1       = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
        model_clear();
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out1", 64'(bus.out1), 64'd0);
        chk("rst out_count", 64'(bus.out_count), 64'd0);

        // Basic packing
        beat(8'h11, 1'b1);
        chk("rst in_ready", 64'(last_in_ready), 64'd1);
        beat(8'h22, 1'b1);
        beat(8'h33, 1'b1);
        beat(8'h44, 1'b1);
        chk("t1 out1", 64'(bus.out1), 64'h44332211);
        chk("t1 out_count", 64'(bus.out_count), 64'd4);
        chk("t1 out_valid", 64'(bus.out_valid), 64'd1);
        idle(1'b1);
        chk("t1 valid one cycle", 64'(bus.out_valid), 64'd0);

        // Back-pressure
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        chk("t2 held out1", 64'(bus.out1), 64'h44332211);
        beat(8'hA4, 1'b0);
        chk("t2 in_ready low", 64'(last_in_ready), 64'd0);
        beat(8'hA4, 1'b1);
        chk("t2 out1", 64'(bus.out1), 64'hA4A3A2A1);
        chk("t2 out_valid", 64'(bus.out_valid), 64'd1);
        idle(1'b1);

        // Partial flush, then the next word starts at lane 0
        beat(8'h5A, 1'b1);
        beat(8'h6B, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3 out1", 64'(bus.out1), 64'h00006B5A);
        chk("t3 out_count", 64'(bus.out_count), 64'd2);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b1);
        beat(8'h03, 1'b1);
        beat(8'h04, 1'b1);
        chk("t3 next word", 64'(bus.out1), 64'h04030201);

        // Flush together with a beat; flush on empty is a no-op
        beat(8'h10, 1'b1);
        step(1'b0, 1'b1, 8'h7C, 1'b1, 1'b1);
        chk("t4 out1", 64'(bus.out1), 64'h00007C10);
        chk("t4 out_count", 64'(bus.out_count), 64'd2);
        idle(1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t4 empty flush", 64'(bus.out_valid), 64'd0);

        // Reset mid-operation
        beat(8'h21, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h23, 1'b0);
        beat(8'h24, 1'b0);
        beat(8'h31, 1'b0);
        beat(8'h32, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        chk("t5 out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5 out1", 64'(bus.out1), 64'd0);
        chk("t5 out_count", 64'(bus.out_count), 64'd0);
        beat(8'hC1, 1'b1);
        chk("t5 in_ready", 64'(last_in_ready), 64'd1);
        beat(8'hC2, 1'b1);
        beat(8'hC3, 1'b1);
        beat(8'hC4, 1'b1);
        chk("t5 fresh word", 64'(bus.out1), 64'hC4C3C2C1);
        chk("t5 fresh count", 64'(bus.out_count), 64'd4);

        // IN_W=4, LANES=3 instance
        bus2.en  = 1'b1;
        bus2.in1 = 4'h1;
        idle(1'b1);
        bus2.in1 = 4'h2;
        idle(1'b1);
        bus2.in1 = 4'h3;
        idle(1'b1);
        bus2.en  = 1'b0;
        chk("t6 out1", 64'(bus2.out1), 64'h321);
        chk("t6 out_count", 64'(bus2.out_count), 64'd3);
        chk("t6 out_valid", 64'(bus2.out_valid), 64'd1);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 8'($urandom),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
